// File: rtl/fib_vec_gen.sv
// fib_vec_gen: streams a k-term Fibonacci-style vector seeded by f1/f2 on an AXI-Stream-like output.
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   f1_tdata, f2_tdata       seed terms, captured with the command
//   k_tdata/k_tvalid/k_tready  command: vector length and its handshake
//   ind_tdata/ind_tvalid/ind_tready  output term stream
//   ind_tuser, ind_tlast     first-beat and last-beat markers
// Build option: define FIB_VEC_GEN_SAT_EN to saturate sums at all-ones instead of wrapping.
module fib_vec_gen #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] f1_tdata,
    input  logic [DATA_WIDTH-1:0] f2_tdata,
    input  logic [DATA_WIDTH-1:0] k_tdata,
    input  logic                  k_tvalid,
    output logic                  k_tready,
    output logic                  ind_tvalid,
    input  logic                  ind_tready,
    output logic [DATA_WIDTH-1:0] ind_tdata,
    output logic                  ind_tuser,
    output logic                  ind_tlast
);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t                r_state, w_state_nxt;
    logic                  r_k_tready, r_tvalid, r_tuser, r_tlast;
    logic [DATA_WIDTH-1:0] r_tdata, r_next, r_cnt, w_term;
    logic                  w_accept, w_beat;
    // r_tdata is the term on the bus, r_next the one after it; r_cnt counts beats left after the current one
`ifdef FIB_VEC_GEN_SAT_EN
    logic [DATA_WIDTH:0] w_sum;
    assign w_sum  = {1'b0, r_tdata} + {1'b0, r_next};
    assign w_term = w_sum[DATA_WIDTH] ? '1 : w_sum[DATA_WIDTH-1:0];
`else
    assign w_term = r_tdata + r_next;
`endif
    assign w_accept = k_tvalid && r_k_tready;
    assign w_beat   = r_tvalid && ind_tready;
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE)
            w_state_nxt = (w_accept && k_tdata != '0) ? STREAM : IDLE;
        else
            w_state_nxt = (w_beat && r_tlast) ? IDLE : STREAM;
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_k_tready <= 1'b0;
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_next     <= '0;
            r_cnt      <= '0;
            r_tuser    <= 1'b0;
            r_tlast    <= 1'b0;
        end else begin
            r_k_tready <= (w_state_nxt == IDLE);
            r_tvalid   <= (w_state_nxt == STREAM);
            if (w_accept) begin
                r_tdata <= f1_tdata;
                r_next  <= f2_tdata;
                r_cnt   <= k_tdata - DATA_WIDTH'(1);
                r_tuser <= (k_tdata != '0);
                r_tlast <= (k_tdata == DATA_WIDTH'(1));
            end else if (w_beat) begin
                r_tuser <= 1'b0;
                // the last beat leaves data in place; only the markers clear
                r_tlast <= r_tlast ? 1'b0 : (r_cnt == DATA_WIDTH'(1));
                if (!r_tlast) begin
                    r_tdata <= r_next;
                    r_next  <= w_term;
                    r_cnt   <= r_cnt - DATA_WIDTH'(1);
                end
            end
        end
    end
    assign k_tready   = r_k_tready;
    assign ind_tvalid = r_tvalid;
    assign ind_tdata  = r_tdata;
    assign ind_tuser  = r_tuser;
    assign ind_tlast  = r_tlast;
endmodule

// File: tb/tb_fib_vec_gen.sv
// tb_fib_vec_gen: directed table-driven bench for fib_vec_gen.
module tb_fib_vec_gen;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] f1_tdata = '0, f2_tdata = '0, k_tdata = '0, ind_tdata;
    logic        k_tvalid = 1'b0, k_tready, ind_tvalid, ind_tready = 1'b1, ind_tuser, ind_tlast;
    int          n_chk = 0, n_pass = 0;

    typedef struct packed {
        logic [31:0]      f1;
        logic [31:0]      f2;
        logic [31:0]      k;
        logic             stall;
        logic [7:0][31:0] exp;
    } vec_t;

    vec_t tbl [6];

    fib_vec_gen #(.DATA_WIDTH(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .f1_tdata(f1_tdata), .f2_tdata(f2_tdata), .k_tdata(k_tdata),
        .k_tvalid(k_tvalid), .k_tready(k_tready),
        .ind_tvalid(ind_tvalid), .ind_tready(ind_tready), .ind_tdata(ind_tdata),
        .ind_tuser(ind_tuser), .ind_tlast(ind_tlast)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic vec_t mk(input logic [31:0] f1, f2, k, input logic stall,
                                input logic [31:0] e0, e1, e2, e3, e4, e5, e6, e7);
        mk.f1 = f1; mk.f2 = f2; mk.k = k; mk.stall = stall;
        mk.exp = {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    task automatic run_vec(input vec_t v);
        int got, cyc;
        logic [31:0] hd;
        logic hu, hl, held;
        @(negedge aclk);
        chk("k_tready_idle", {31'b0, k_tready}, 1);
        f1_tdata = v.f1; f2_tdata = v.f2; k_tdata = v.k; k_tvalid = 1'b1; ind_tready = 1'b1;
        @(negedge aclk);
        k_tvalid = 1'b0;
        chk("k_tready_busy", {31'b0, k_tready}, 0);
        got = 0; cyc = 0; held = 1'b0; hd = '0; hu = 1'b0; hl = 1'b0;
        while (got < int'(v.k) && cyc < 40) begin
            if (held) begin
                chk("hold_data", ind_tdata, hd);
                chk("hold_flags", {30'b0, ind_tuser, ind_tlast}, {30'b0, hu, hl});
            end
            held = 1'b0;
            if (ind_tvalid && ind_tready) begin
                chk("beat_data", ind_tdata, v.exp[got]);
                chk("beat_tuser", {31'b0, ind_tuser}, {31'b0, got == 0});
                chk("beat_tlast", {31'b0, ind_tlast}, {31'b0, got == int'(v.k) - 1});
                got++;
            end else if (ind_tvalid) begin
                hd = ind_tdata; hu = ind_tuser; hl = ind_tlast; held = 1'b1;
            end
            @(negedge aclk);
            cyc++;
            if (v.stall) ind_tready = ~ind_tready;
        end
        chk("beat_count", got, v.k);
        if (!v.stall) chk("no_bubbles", cyc, v.k);
        chk("done_tvalid", {31'b0, ind_tvalid}, 0);
        chk("done_k_tready", {31'b0, k_tready}, 1);
        ind_tready = 1'b1;
    endtask

    initial begin
        tbl[0] = mk(1, 1, 8, 0, 1, 1, 2, 3, 5, 8, 13, 21);
        tbl[1] = mk(7, 9, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        tbl[2] = mk(2, 3, 5, 1, 2, 3, 5, 8, 13, 0, 0, 0);
`ifdef FIB_VEC_GEN_SAT_EN
        tbl[3] = mk(32'hFFFF_FFFF, 1, 3, 0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
`else
        tbl[3] = mk(32'hFFFF_FFFF, 1, 3, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0);
`endif
        tbl[4] = mk(10, 20, 4, 0, 10, 20, 30, 50, 0, 0, 0, 0);
        tbl[5] = mk(5, 0, 3, 1, 5, 0, 5, 0, 0, 0, 0, 0);

        // reset state
        #12;
        chk("rst_k_tready", {31'b0, k_tready}, 0);
        chk("rst_tvalid", {31'b0, ind_tvalid}, 0);
        chk("rst_tdata", ind_tdata, 0);
        chk("rst_flags", {30'b0, ind_tuser, ind_tlast}, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_release_k_tready", {31'b0, k_tready}, 1);

        foreach (tbl[i]) run_vec(tbl[i]);

        // k == 0: no beats and ready never drops
        @(negedge aclk);
        f1_tdata = 3; f2_tdata = 4; k_tdata = 0; k_tvalid = 1'b1;
        @(negedge aclk);
        k_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("k0_tvalid", {31'b0, ind_tvalid}, 0);
            chk("k0_k_tready", {31'b0, k_tready}, 1);
            @(negedge aclk);
        end

        // reset in the middle of a k=8 vector
        f1_tdata = 1; f2_tdata = 1; k_tdata = 8; k_tvalid = 1'b1; ind_tready = 1'b1;
        @(negedge aclk);
        k_tvalid = 1'b0;
        chk("mid_beat0", ind_tdata, 1);
        @(negedge aclk);
        chk("mid_beat1", ind_tdata, 1);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", {31'b0, ind_tvalid}, 0);
        chk("mid_rst_k_tready", {31'b0, k_tready}, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("post_rst_tvalid", {31'b0, ind_tvalid}, 0);
            chk("post_rst_k_tready", {31'b0, k_tready}, 1);
        end
        run_vec(mk(4, 4, 2, 0, 4, 4, 0, 0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
